// File: rtl/cobertura_ctrl.sv
// Cover controller: closes the cover on rain or humidity, reopens it after
// a debounced dry spell, bounds every motor run with a timeout and inserts
// a motor-off pause whenever an opening run has to be reversed.
module cobertura_ctrl #(
  parameter int unsigned DEB  = 8,
  parameter int unsigned TMO  = 1000,
  parameter int unsigned DEAD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       L,
  input  logic       U,
  input  logic       Fd,
  input  logic       Fe,
  input  logic       falha_clr,
  output logic       A,
  output logic       F,
  output logic [2:0] estado,
  output logic       falha
);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    ABERTO   = 3'd1,
    FECHANDO = 3'd2,
    FECHADO  = 3'd3,
    ABRINDO  = 3'd4,
    PAUSA    = 3'd5,
    FALHA    = 3'd6,
    ILEGAL   = 3'd7
  } state_t;

  localparam logic [15:0] DEB_C   = 16'(DEB);
  localparam logic [15:0] TMO_C   = 16'(TMO - 1);
  localparam logic [15:0] DEAD_C  = 16'(DEAD - 1);

  logic [1:0]  syncL_q, syncU_q, syncFd_q, syncFe_q;
  logic        sL, sU, sFd, sFe, chuva;
  logic [15:0] dryCnt_q, dryCnt_d;
  logic [15:0] motCnt_q, motCnt_d;
  logic        secoOk, timeout, pauseDone;
  state_t      state_q, state_d;

  // Two-flop synchronizers for the asynchronous sensor and limit inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncL_q  <= 2'b00;
      syncU_q  <= 2'b00;
      syncFd_q <= 2'b00;
      syncFe_q <= 2'b00;
    end else begin
      syncL_q  <= {syncL_q[0], L};
      syncU_q  <= {syncU_q[0], U};
      syncFd_q <= {syncFd_q[0], Fd};
      syncFe_q <= {syncFe_q[0], Fe};
    end
  end

  assign sL    = syncL_q[1];
  assign sU    = syncU_q[1];
  assign sFd   = syncFd_q[1];
  assign sFe   = syncFe_q[1];
  assign chuva = sL | sU;

  assign secoOk    = (dryCnt_q == DEB_C);
  assign timeout   = (motCnt_q == TMO_C);
  assign pauseDone = (motCnt_q == DEAD_C);

  // Dry-spell counter: any rain restarts it, otherwise it saturates at DEB.
  always_comb begin
    dryCnt_d = dryCnt_q;
    if (chuva) begin
      dryCnt_d = 16'd0;
    end else if (!secoOk) begin
      dryCnt_d = dryCnt_q + 16'd1;
    end
  end

  // Next-state logic; a both-limits-active reading is treated as a broken switch.
  always_comb begin
    state_d = state_q;
    if (state_q != FALHA && sFd && sFe) begin
      state_d = FALHA;
    end else begin
      case (state_q)
        INIT: begin
          if (chuva)    state_d = sFe ? FECHADO : FECHANDO;
          else if (sFd) state_d = ABERTO;
          else if (sFe) state_d = FECHADO;
          else          state_d = FECHANDO;
        end
        ABERTO: begin
          if (chuva) state_d = FECHANDO;
        end
        FECHANDO: begin
          if (sFe)          state_d = FECHADO;
          else if (timeout) state_d = FALHA;
        end
        FECHADO: begin
          if (secoOk && !sFd) state_d = ABRINDO;
        end
        ABRINDO: begin
          if (chuva)        state_d = PAUSA;
          else if (sFd)     state_d = ABERTO;
          else if (timeout) state_d = FALHA;
        end
        PAUSA: begin
          if (pauseDone) state_d = FECHANDO;
        end
        FALHA: begin
          if (falha_clr) state_d = INIT;
        end
        default: state_d = FALHA;
      endcase
    end
  end

  // Motion/pause counter restarts on entry to a timed state and counts while in it.
  always_comb begin
    motCnt_d = motCnt_q;
    if ((state_d == FECHANDO || state_d == ABRINDO || state_d == PAUSA) &&
        (state_d != state_q)) begin
      motCnt_d = 16'd0;
    end else if (state_q == FECHANDO || state_q == ABRINDO || state_q == PAUSA) begin
      motCnt_d = motCnt_q + 16'd1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      dryCnt_q <= 16'd0;
      motCnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      dryCnt_q <= dryCnt_d;
      motCnt_q <= motCnt_d;
    end
  end

  assign A      = (state_q == ABRINDO);
  assign F      = (state_q == FECHANDO);
  assign falha  = (state_q == FALHA);
  assign estado = state_q;

endmodule

// File: tb/tb_cobertura_ctrl.sv
// Bench for cobertura_ctrl with DEB=4, TMO=20, DEAD=2. The stimulus process
// queues every expected output change (with the number of cycles the previous
// state should have lasted); the monitor pops an entry whenever the DUT
// outputs change and compares.
module tb_cobertura_ctrl;

  localparam int DEB  = 4;
  localparam int TMO  = 20;
  localparam int DEAD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       L, U, Fd, Fe, falha_clr;
  logic       A, F, falha;
  logic [2:0] estado;

  typedef struct {
    logic [2:0] st;
    logic       a;
    logic       f;
    logic       fl;
    int         dur;
    logic       src;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  cobertura_ctrl #(.DEB(DEB), .TMO(TMO), .DEAD(DEAD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .L         (L),
    .U         (U),
    .Fd        (Fd),
    .Fe        (Fe),
    .falha_clr (falha_clr),
    .A         (A),
    .F         (F),
    .estado    (estado),
    .falha     (falha)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Queue one expected output change.
  task automatic pushExp(input logic [2:0] st, input logic a, input logic f,
                         input logic fl, input int dur, input logic src);
    exp_t e;
    e.st = st; e.a = a; e.f = f; e.fl = fl; e.dur = dur; e.src = src;
    expQ.push_back(e);
  endtask

  // Drive the sensor and limit inputs.
  task automatic applyStimulus(input logic lv, input logic uv,
                               input logic fdv, input logic fev);
    L = lv; U = uv; Fd = fdv; Fe = fev;
  endtask

  // One-cycle fault acknowledge, issued right after a falling edge.
  task automatic pulseClear();
    falha_clr = 1'b1;
    @(negedge clk);
    falha_clr = 1'b0;
  endtask

  // Wait (bounded) until the state code shows up, sampled after a falling edge.
  task automatic waitState(input logic [2:0] code, input int budget);
    int  n   = 0;
    bit  hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      #2;
      n++;
      if (estado == code) hit = 1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_state: estado=%0d, required %0d within %0d cycles",
               estado, code, budget);
    end
  endtask

  // Compare one observed output change against the popped expectation.
  task automatic checkOutput(input exp_t e, input int durSeen, input logic srcSeen);
    total++;
    if (estado !== e.st || A !== e.a || F !== e.f || falha !== e.fl) begin
      bad++;
      $display("[TB] FAIL outputs: got estado=%0d A=%0d F=%0d falha=%0d, required estado=%0d A=%0d F=%0d falha=%0d",
               estado, A, F, falha, e.st, e.a, e.f, e.fl);
    end
    if (e.dur >= 0) begin
      total++;
      if (durSeen != e.dur) begin
        bad++;
        $display("[TB] FAIL duration before estado=%0d: got %0d cycles, required %0d",
                 e.st, durSeen, e.dur);
      end
    end
    total++;
    if (srcSeen !== e.src) begin
      bad++;
      $display("[TB] FAIL change_source estado=%0d: got %0d, required %0d (1 = reset without clock edge)",
               e.st, srcSeen, e.src);
    end
  endtask

  // Monitor: samples after each falling clock edge and right after reset
  // assertion; every output change consumes one queued expectation.
  initial begin
    int   prevKey = -1;
    int   dur     = 0;
    int   key;
    logic src;
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      src = clk;
      #1;
      total++;
      if (A && F) begin
        bad++;
        $display("[TB] FAIL exclusive_drive: got A=%0d F=%0d, required not both 1", A, F);
      end
      key = int'({estado, A, F, falha});
      if (key != prevKey) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_change: got estado=%0d A=%0d F=%0d falha=%0d, required no change",
                   estado, A, F, falha);
        end else begin
          e = expQ.pop_front();
          checkOutput(e, dur, src);
        end
        prevKey = key;
        dur     = 1;
      end else if (!src) begin
        dur++;
      end
    end
  end

  // Directed scenario.
  initial begin
    rst_n     = 1'b0;
    falha_clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Power-up with the cover closed: synchronizers start at 0, so INIT first
    // sees no limit and briefly closes, then settles in FECHADO and reopens.
    pushExp(3'd0, 0, 0, 0, -1, 0);
    pushExp(3'd2, 0, 1, 0, -1, 0);
    pushExp(3'd3, 0, 0, 0, 2, 0);
    pushExp(3'd4, 1, 0, 0, 2, 0);
    pushExp(3'd1, 0, 0, 0, 3, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitState(3'd4, 40);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitState(3'd1, 20);

    // Rain while open closes; dry spell reopens.
    pushExp(3'd2, 0, 1, 0, 3, 0);
    pushExp(3'd3, 0, 0, 0, 8, 0);
    pushExp(3'd4, 1, 0, 0, 7, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitState(3'd2, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitState(3'd3, 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(3'd4, 40);

    // Humidity pulse during opening: dead-time pause, then close.
    pushExp(3'd5, 0, 0, 0, 3, 0);
    pushExp(3'd2, 0, 1, 0, 2, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Closing never reaches the limit: timeout after TMO cycles, then clear.
    pushExp(3'd6, 0, 0, 1, 20, 0);
    pushExp(3'd0, 0, 0, 0, 4, 0);
    pushExp(3'd1, 0, 0, 0, 1, 0);
    waitState(3'd6, 60);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    pulseClear();
    waitState(3'd1, 20);

    // Both limits active from ABERTO, FECHADO and ABRINDO.
    pushExp(3'd6, 0, 0, 1, 3, 0);
    pushExp(3'd0, 0, 0, 0, 4, 0);
    pushExp(3'd3, 0, 0, 0, 1, 0);
    pushExp(3'd6, 0, 0, 1, 3, 0);
    pushExp(3'd0, 0, 0, 0, 4, 0);
    pushExp(3'd3, 0, 0, 0, 1, 0);
    pushExp(3'd4, 1, 0, 0, 2, 0);
    pushExp(3'd6, 0, 0, 1, 3, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitState(3'd6, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    pulseClear();
    waitState(3'd3, 20);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitState(3'd6, 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    pulseClear();
    waitState(3'd4, 20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitState(3'd6, 20);

    // Reset asserted between edges while opening stops the motor at once.
    pushExp(3'd0, 0, 0, 0, 4, 0);
    pushExp(3'd3, 0, 0, 0, 1, 0);
    pushExp(3'd4, 1, 0, 0, 1, 0);
    pushExp(3'd0, 0, 0, 0, 1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    pulseClear();
    waitState(3'd4, 20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;

    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL pending_expectations: got %0d left, required 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
